// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the multiply/accumulate datapath.
// Number format: sign[15], exp[14:10], mant[9:0], bias 15.
// Exponent 0 means zero; no infinity/NaN encodings exist.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int GUARD_W = 3;
  // Working mantissa: hidden one + fraction + guard bits.
  localparam int WM_W    = MAN_W + GUARD_W + 1;

  localparam int          FP16_BIAS       = 15;
  localparam int          FP16_EXP_MAX    = 30;
  localparam logic [14:0] FP16_MAX_FINITE = 15'h7BFF;
  localparam logic [14:0] FP16_ONE        = 15'h3C00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_OUT
  } state_t;

  // {1, mant, guard zeros}; an exponent-0 operand contributes nothing.
  function automatic logic [WM_W-1:0] work_mant(input logic [15:0] x);
    return (x[14:10] == '0) ? '0 : {1'b1, x[9:0], {GUARD_W{1'b0}}};
  endfunction

  // Magnitude ordering key; every exponent-0 encoding sorts as zero.
  function automatic logic [14:0] mag_key(input logic [15:0] x);
    return (x[14:10] == '0) ? '0 : x[14:0];
  endfunction

  // Effective sign; any zero (including -0) is treated as +0.
  function automatic logic eff_sign(input logic [15:0] x);
    return (x[14:10] == '0) ? 1'b0 : x[15];
  endfunction

endpackage

// File: rtl/fp16_norm.sv
// Combinational FP16 normaliser: leading-one detect, shift, exponent
// adjust, overflow saturation and underflow flush. Takes a 15-bit raw
// sum whose bit 13 carries weight 1.0 at exponent expo.
module fp16_norm
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  expo,
  input  logic [WM_W:0]     mant,
  output logic [15:0]       result
);

  logic [3:0]        lz;
  logic [MAN_W-1:0]  frac;
  logic signed [6:0] e_n;

  // Leading-zero count of the lower 14 bits relative to bit 13.
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < WM_W; i++)
      if (mant[i]) lz = 4'(WM_W - 1 - i);
  end

  // Bring the leading one to bit 13 (or drop the carry), truncating.
  always_comb begin
    if (mant[WM_W]) begin
      frac = mant[WM_W-1:GUARD_W+1];
      e_n  = $signed({2'b00, expo}) + 7'sd1;
    end else begin
      frac = MAN_W'((mant[WM_W-1:0] << lz) >> GUARD_W);
      e_n  = $signed({2'b00, expo}) - $signed({3'b000, lz});
    end
  end

  // Exact zero and underflow flush to +0; overflow saturates to max finite.
  always_comb begin
    if (mant == '0)
      result = 16'h0000;
    else if (e_n > 7'(FP16_EXP_MAX))
      result = {sign, FP16_MAX_FINITE};
    else if (e_n < 7'sd1)
      result = 16'h0000;
    else
      result = {sign, e_n[EXP_W-1:0], frac};
  end

endmodule

// File: rtl/fp16_accum.sv
// Sequential FP16 accumulator: sums a stream of operands (one per 4-cycle
// pass) and emits the total plus a saturating term count on in_last.
module fp16_accum
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  state_t            state;
  logic [15:0]       acc;
  logic [15:0]       op;
  logic              last_q;
  logic [CNT_W-1:0]  cnt;

  // Aligned operands (ALIGN -> ADD).
  logic [WM_W-1:0]   big_m, sml_m;
  logic              big_s, sml_s;
  logic [EXP_W-1:0]  big_e;

  // Raw sum (ADD -> NORM).
  logic [WM_W:0]     sum;
  logic              sum_s;
  logic [EXP_W-1:0]  sum_e;

  logic              op_big;
  logic [15:0]       big, sml;
  logic [EXP_W-1:0]  ediff;
  logic [WM_W-1:0]   sml_sh;
  logic [15:0]       norm_res;

  // Order accumulator/operand by magnitude and align the smaller one.
  always_comb begin
    op_big = mag_key(op) > mag_key(acc);
    big    = op_big ? op  : acc;
    sml    = op_big ? acc : op;
    ediff  = big[14:10] - sml[14:10];
    sml_sh = (ediff >= 5'd14) ? '0 : (work_mant(sml) >> ediff);
  end

  fp16_norm u_norm (
    .sign   (sum_s),
    .expo   (sum_e),
    .mant   (sum),
    .result (norm_res)
  );

  // Control FSM with the datapath registers it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= 16'h0000;
      op        <= 16'h0000;
      last_q    <= 1'b0;
      cnt       <= '0;
      big_m     <= '0;
      sml_m     <= '0;
      big_s     <= 1'b0;
      sml_s     <= 1'b0;
      big_e     <= '0;
      sum       <= '0;
      sum_s     <= 1'b0;
      sum_e     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op       <= in_data;
            last_q   <= in_last;
            if (cnt != '1) cnt <= cnt + 1'b1;
            in_ready <= 1'b0;
            state    <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          big_m <= work_mant(big);
          sml_m <= sml_sh;
          big_s <= eff_sign(big);
          sml_s <= eff_sign(sml);
          big_e <= big[14:10];
          state <= ST_ADD;
        end
        ST_ADD: begin
          // Larger magnitude is first, so subtraction never goes negative.
          if (big_s == sml_s) sum <= {1'b0, big_m} + {1'b0, sml_m};
          else                sum <= {1'b0, big_m - sml_m};
          sum_s <= big_s;
          sum_e <= big_e;
          state <= ST_NORM;
        end
        ST_NORM: begin
          acc <= norm_res;
          if (last_q) begin
            out_data  <= norm_res;
            out_count <= cnt;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_OUT: begin
          // Result held until taken; the next vector starts from +0.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= 16'h0000;
            cnt       <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accum.sv
// Scoreboard bench for fp16_accum: the driver pushes expected results from
// an integer reference model; a monitor pops on each output handshake.
module tb_fp16_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_accept = 0;
  logic [15:0] m_acc = 16'h0000;
  int          m_cnt = 0;
  logic        rnd_bp = 1'b0;
  logic        ready_force = 1'b1;

  fp16_accum #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact integer significands at 2^-13 granularity relative to
  // the larger operand, the smaller one floored by the exponent gap.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, ma, mb, sa, sb, eh, el, mh, ml, sh, sl, d, r, e;
    longint va, vb;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 8;
    mb = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 8;
    sa = (ea == 0) ? 0 : int'(a[15]);
    sb = (eb == 0) ? 0 : int'(b[15]);
    va = longint'(ma) << ea;
    vb = longint'(mb) << eb;
    if (vb > va) begin eh = eb; mh = mb; sh = sb; el = ea; ml = ma; sl = sa; end
    else         begin eh = ea; mh = ma; sh = sa; el = eb; ml = mb; sl = sb; end
    d  = eh - el;
    ml = (d >= 14) ? 0 : ml / (1 << d);
    r  = (sh == sl) ? mh + ml : mh - ml;
    e  = eh;
    if (r == 0) return 16'h0000;
    while (r >= 16384) begin r = r / 2; e++; end
    while (r < 8192)   begin r = r * 2; e--; end
    if (e > 30) return {1'(sh), 15'h7BFF};
    if (e < 1)  return 16'h0000;
    return {1'(sh), 5'(e), 10'((r - 8192) / 8)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    case ($urandom_range(0, 3))
      0:       e = 5'($urandom_range(0, 31));
      1:       e = 5'd0;
      default: e = 5'($urandom_range(11, 19));
    endcase
    return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
  endfunction

  // Offer one operand, wait (bounded) for acceptance, update the model.
  task automatic send_op(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept timeout: in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_accept = cyc;
    in_valid = 1'b0;
    m_acc = ref_add(m_acc, d);
    if (m_cnt < 255) m_cnt++;
    if (l) begin
      exp_q.push_back({m_acc, 8'(m_cnt)});
      m_acc = 16'h0000;
      m_cnt = 0;
    end
  endtask

  task automatic wait_out(output int at);
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    at = cyc;
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL out_valid timeout: got 0 expected 1");
    end
  endtask

  task automatic do_vec2(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] expd, output int lat);
    int a0, t;
    send_op(a, 1'b0);
    a0 = last_accept;
    send_op(b, 1'b1);
    wait_out(t);
    lat = t - a0;
    check("vec data", out_data, expd);
    check("vec count", {8'h00, out_count}, 16'd2);
    @(posedge clk); #1;
  endtask

  // Output back-pressure driver: random when rnd_bp, else ready_force.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Scoreboard monitor: every accepted result must match the next expected.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected result: got %h expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb data", out_data, mon_e.data);
        check("sb count", {8'h00, out_count}, {8'h00, mon_e.cnt});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t, len;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {15'h0, in_ready}, 16'h1);
    check("reset out_valid", {15'h0, out_valid}, 16'h0);
    check("reset out_data", out_data, 16'h0000);
    check("reset out_count", {8'h00, out_count}, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 + 2.0 = 3.0; result appears in cycle t+8 for accept in cycle t,
    // i.e. visible after the 7th edge following the first accept edge.
    do_vec2(16'h3C00, 16'h4000, 16'h4200, lat);
    check("latency edges", 16'(lat), 16'd7);
    do_vec2(16'h3C00, 16'hBC00, 16'h0000, lat);
    do_vec2(16'h3C00, 16'h1400, 16'h3C01, lat);
    do_vec2(16'h3C00, 16'h0C00, 16'h3C00, lat);
    do_vec2(16'h7BFF, 16'h7BFF, 16'h7BFF, lat);
    do_vec2(16'hFBFF, 16'hFBFF, 16'hFBFF, lat);

    // Back-pressure: result and in_ready must hold while out_ready is low.
    ready_force = 1'b0;
    send_op(16'h3C00, 1'b0);
    send_op(16'h3C00, 1'b1);
    wait_out(t);
    for (int i = 0; i < 5; i++) begin
      check("hold out_valid", {15'h0, out_valid}, 16'h1);
      check("hold out_data", out_data, 16'h4000);
      check("hold out_count", {8'h00, out_count}, 16'd2);
      check("hold in_ready", {15'h0, in_ready}, 16'h0);
      @(negedge clk);
    end
    ready_force = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    send_op(16'h4000, 1'b1);
    wait_out(t);
    check("after bp data", out_data, 16'h4000);
    check("after bp count", {8'h00, out_count}, 16'd1);
    @(posedge clk); #1;

    // Reset during ADD discards the operand and clears the outputs at once.
    send_op(16'h3C00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", {15'h0, out_valid}, 16'h0);
    check("midrst in_ready", {15'h0, in_ready}, 16'h1);
    check("midrst out_count", {8'h00, out_count}, 16'h0);
    exp_q.delete();
    m_acc = 16'h0000; m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_op(16'h3800, 1'b1);
    wait_out(t);
    check("post rst data", out_data, 16'h3800);
    check("post rst count", {8'h00, out_count}, 16'd1);
    @(posedge clk); #1;

    // Random vectors with random output back-pressure.
    rnd_bp = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) send_op(rand_op(), k == len - 1);
    end
    // Long vector: count saturates at 255.
    for (int k = 0; k < 300; k++) send_op(rand_op(), k == 299);
    rnd_bp = 1'b0;
    ready_force = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("queue drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
